// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the HDMI receive/transmit path.
// Holds the symbol width, the four control tokens (shared with the encoder),
// the word-alignment state encoding and a small popcount helper.
package tmds_pkg;

  localparam int unsigned SYM_W = 10;

  // Control tokens, written TMDS[9:0] (bit 0 is first on the wire).
  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  // Word-alignment states (legacy-compatible constant encoding).
  localparam logic [1:0] ST_SEARCH    = 2'd0;
  localparam logic [1:0] ST_SLIP_WAIT = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder.
// Ports:
//   sym_i      10-bit raw symbol
//   is_ctrl_o  symbol is one of the four control tokens
//   cd_o       control data for a token (0 otherwise)
//   vd_o       decoded video data (meaningful for data symbols)
//   invalid_o  data symbol whose transition-minimisation bit is inconsistent
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  output logic             is_ctrl_o,
  output logic [1:0]       cd_o,
  output logic [7:0]       vd_o,
  output logic             invalid_o
);

  logic [7:0] d;
  logic [3:0] n;
  logic       x;

  always_comb begin
    is_ctrl_o = 1'b1;
    cd_o      = 2'b00;
    unique case (sym_i)
      CTRL_00: cd_o = 2'b00;
      CTRL_01: cd_o = 2'b01;
      CTRL_10: cd_o = 2'b10;
      CTRL_11: cd_o = 2'b11;
      default: is_ctrl_o = 1'b0;
    endcase

    // Undo the DC-balance inversion, then the XOR/XNOR chain.
    d       = sym_i[7:0] ^ {8{sym_i[9]}};
    vd_o    = '0;
    vd_o[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      vd_o[i] = sym_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end

    // The encoder would have chosen XNOR (bit 8 = 0) exactly when x is set.
    n         = ones8(vd_o);
    x         = (n > 4'd4) || ((n == 4'd4) && !vd_o[0]);
    invalid_o = !is_ctrl_o && (sym_i[8] == x);
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with word-alignment FSM.
// Decodes one 10-bit symbol per pixel clock (1-cycle latency) and aligns the
// upstream deserializer by pulsing bitslip until control tokens appear.
// Ports:
//   clk, rst  pixel clock, synchronous active-high reset
//   TMDS      raw 10-bit symbol
//   VD/CD/VDE decoded video data, control data, data-enable (zero unless locked)
//   locked    alignment achieved
//   bitslip   one-cycle request to shift the word boundary by one bit
//   sym_err   current output is an invalid data symbol
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_TOKENS    = 8,
  parameter int unsigned ERR_LIMIT      = 4,
  parameter int unsigned SEARCH_TIMEOUT = 1023,
  parameter int unsigned SLIP_WAIT      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] TMDS,
  output logic [7:0]       VD,
  output logic [1:0]       CD,
  output logic             VDE,
  output logic             locked,
  output logic             bitslip,
  output logic             sym_err
);

  localparam int unsigned TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned ERR_W  = $clog2(ERR_LIMIT + 1);
  localparam int unsigned IDLE_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [TOK_W-1:0]  TOK_MAX  = TOK_W'(LOCK_TOKENS);
  localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(ERR_LIMIT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SEARCH_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SLIP_WAIT);

  logic        is_ctrl;
  logic [1:0]  dec_cd;
  logic [7:0]  dec_vd;
  logic        dec_inv;

  tmds_symbol_decode u_dec (
    .sym_i     (TMDS),
    .is_ctrl_o (is_ctrl),
    .cd_o      (dec_cd),
    .vd_o      (dec_vd),
    .invalid_o (dec_inv)
  );

  logic [1:0]        state_q,    state_d;
  logic [TOK_W-1:0]  tok_cnt_q,  tok_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]        vd_q,       vd_d;
  logic [1:0]        cd_q,       cd_d;
  logic              vde_q,      vde_d;
  logic              sym_err_q,  sym_err_d;
  logic              bitslip_q,  bitslip_d;

  always_comb begin
    state_d    = state_q;
    tok_cnt_d  = tok_cnt_q;
    err_cnt_d  = err_cnt_q;
    idle_cnt_d = idle_cnt_q;
    wait_cnt_d = wait_cnt_q;
    bitslip_d  = 1'b0;

    // Counters saturate at their threshold; each threshold forces a state
    // change on the same edge, so saturation only guards odd parameter sets.
    unique case (state_q)
      ST_SEARCH: begin
        if (is_ctrl) begin
          idle_cnt_d = '0;
          tok_cnt_d  = (tok_cnt_q == TOK_MAX) ? tok_cnt_q : tok_cnt_q + TOK_W'(1);
          if (tok_cnt_d == TOK_MAX) begin
            state_d    = ST_LOCKED;
            tok_cnt_d  = '0;
            err_cnt_d  = '0;
          end
        end else begin
          tok_cnt_d  = '0;
          idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
          if (idle_cnt_d == IDLE_MAX) begin
            state_d    = ST_SLIP_WAIT;
            bitslip_d  = 1'b1;
            idle_cnt_d = '0;
            wait_cnt_d = '0;
          end
        end
      end
      ST_SLIP_WAIT: begin
        wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_d == WAIT_MAX) begin
          state_d    = ST_SEARCH;
          tok_cnt_d  = '0;
          idle_cnt_d = '0;
          wait_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (is_ctrl) begin
          err_cnt_d  = '0;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
          if (dec_inv) begin
            err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_W'(1);
          end
        end
        if ((err_cnt_d == ERR_MAX) || (idle_cnt_d == IDLE_MAX)) begin
          state_d    = ST_SEARCH;
          tok_cnt_d  = '0;
          err_cnt_d  = '0;
          idle_cnt_d = '0;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        tok_cnt_d  = '0;
        err_cnt_d  = '0;
        idle_cnt_d = '0;
        wait_cnt_d = '0;
      end
    endcase

    // Outputs are gated by the state being entered, not the current one.
    vd_d      = '0;
    cd_d      = '0;
    vde_d     = 1'b0;
    sym_err_d = 1'b0;
    if (state_d == ST_LOCKED) begin
      if (is_ctrl) begin
        cd_d = dec_cd;
      end else begin
        vd_d      = dec_vd;
        vde_d     = 1'b1;
        sym_err_d = dec_inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      tok_cnt_q  <= '0;
      err_cnt_q  <= '0;
      idle_cnt_q <= '0;
      wait_cnt_q <= '0;
      vd_q       <= '0;
      cd_q       <= '0;
      vde_q      <= 1'b0;
      sym_err_q  <= 1'b0;
      bitslip_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tok_cnt_q  <= tok_cnt_d;
      err_cnt_q  <= err_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      vd_q       <= vd_d;
      cd_q       <= cd_d;
      vde_q      <= vde_d;
      sym_err_q  <= sym_err_d;
      bitslip_q  <= bitslip_d;
    end
  end

  assign VD      = vd_q;
  assign CD      = cd_q;
  assign VDE     = vde_q;
  assign sym_err = sym_err_q;
  assign bitslip = bitslip_q;
  assign locked  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tmds_decoder.sv
module tb_tmds_decoder;

  localparam int LT = 8;
  localparam int EL = 4;
  localparam int TO = 1023;
  localparam int SW = 16;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] TMDS = '0;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE, locked, bitslip, sym_err;

  tmds_decoder #(
    .LOCK_TOKENS   (LT),
    .ERR_LIMIT     (EL),
    .SEARCH_TIMEOUT(TO),
    .SLIP_WAIT     (SW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .TMDS   (TMDS),
    .VD     (VD),
    .CD     (CD),
    .VDE    (VDE),
    .locked (locked),
    .bitslip(bitslip),
    .sym_err(sym_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = searching, 1 = waiting after slip, 2 = locked.
  int m_st = 0, m_tok = 0, m_idle = 0, m_err = 0, m_wait = 0;
  logic [13:0] m_exp = '0;

  function automatic logic [13:0] E(input logic [7:0] vd, input logic [1:0] cd,
                                    input logic vde, input logic lk,
                                    input logic bs, input logic se);
    return {vd, cd, vde, lk, bs, se};
  endfunction

  function automatic logic [13:0] dut_out();
    return {VD, CD, VDE, locked, bitslip, sym_err};
  endfunction

  task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {VD,CD,VDE,lk,bs,err}=%b_%b_%b%b%b%b want %b_%b_%b%b%b%b",
               nm, act[13:6], act[5:4], act[3], act[2], act[1], act[0],
               exp[13:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic model_step(input logic r, input logic [9:0] t);
    logic       tok, inv, slip, x;
    logic [1:0] cd;
    logic [7:0] d, vd;
    int         n;
    logic [9:0] toks [4];
    toks[0] = T0; toks[1] = T1; toks[2] = T2; toks[3] = T3;
    tok = 1'b0; cd = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (t == toks[k]) begin
        tok = 1'b1;
        cd  = 2'(k);
      end
    end
    d = t[7:0] ^ {8{t[9]}};
    vd[0] = d[0];
    for (int i = 1; i < 8; i++) vd[i] = t[8] ? (d[i] ^ d[i-1]) : !(d[i] ^ d[i-1]);
    n   = $countones(vd);
    x   = (n > 4) || (n == 4 && vd[0] == 1'b0);
    inv = !tok && (t[8] != !x);
    slip = 1'b0;
    if (r) begin
      m_st = 0; m_tok = 0; m_idle = 0; m_err = 0; m_wait = 0;
    end else if (m_st == 0) begin
      if (tok) begin
        m_idle = 0; m_tok++;
        if (m_tok == LT) begin m_st = 2; m_err = 0; m_tok = 0; end
      end else begin
        m_tok = 0; m_idle++;
        if (m_idle == TO) begin slip = 1'b1; m_st = 1; m_wait = 0; m_idle = 0; end
      end
    end else if (m_st == 1) begin
      m_wait++;
      if (m_wait == SW) begin m_st = 0; m_tok = 0; m_idle = 0; m_wait = 0; end
    end else begin
      if (tok) begin m_err = 0; m_idle = 0; end
      else begin m_idle++; if (inv) m_err++; end
      if (m_err == EL || m_idle == TO) begin
        m_st = 0; m_tok = 0; m_idle = 0; m_err = 0;
      end
    end
    if (m_st == 2) m_exp = tok ? E(8'h00, cd, 1'b0, 1'b1, slip, 1'b0)
                               : E(vd, 2'b00, 1'b1, 1'b1, slip, inv);
    else           m_exp = E(8'h00, 2'b00, 1'b0, 1'b0, slip, 1'b0);
  endtask

  // Drive one symbol, advance one edge, and compare against the model.
  task automatic cycle(input logic r, input logic [9:0] t);
    rst  = r;
    TMDS = t;
    @(posedge clk);
    model_step(r, t);
    #1;
    check("model", dut_out(), m_exp);
  endtask

  function automatic logic [9:0] rnd_data();
    logic [9:0] s;
    s = 10'($urandom);
    if (s == T0 || s == T1 || s == T2 || s == T3) s = 10'h1FF;
    return s;
  endfunction

  typedef struct {
    logic        r;
    logic [9:0]  t;
    int          reps;
    logic [13:0] exp;
  } vec_t;

  vec_t vq[$];

  initial begin
    logic [13:0] Z;
    int burst;
    Z = E(8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- directed table ----------------
    vq.push_back('{1'b1, 10'h2AB,       3,  Z});
    vq.push_back('{1'b0, 10'h1FF,       20, Z});
    vq.push_back('{1'b0, T0,            7,  Z});
    vq.push_back('{1'b0, T0,            1,  E(8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0)});
    vq.push_back('{1'b0, T1,            1,  E(8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0)});
    vq.push_back('{1'b0, 10'b0100000000, 1, E(8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0)});
    vq.push_back('{1'b0, 10'b1000000000, 1, E(8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0)});
    vq.push_back('{1'b0, 10'b0101010101, 3, E(8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1)});
    vq.push_back('{1'b0, T2,            1,  E(8'h00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0)});
    vq.push_back('{1'b0, 10'b0101010101, 3, E(8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1)});
    vq.push_back('{1'b0, 10'b0101010101, 1, Z});
    vq.push_back('{1'b0, T3,            7,  Z});
    vq.push_back('{1'b0, T3,            1,  E(8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0)});
    vq.push_back('{1'b0, 10'b1000000000, 1, E(8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0)});
    vq.push_back('{1'b1, 10'b1000000000, 1, Z});
    vq.push_back('{1'b0, T0,            7,  Z});
    vq.push_back('{1'b0, T0,            1,  E(8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0)});

    for (int v = 0; v < vq.size(); v++) begin
      for (int k = 0; k < vq[v].reps; k++) begin
        cycle(vq[v].r, vq[v].t);
        check($sformatf("vec[%0d].%0d", v, k), dut_out(), vq[v].exp);
      end
    end

    // ---------------- slip schedule ----------------
    cycle(1'b1, 10'h1FF);
    for (int k = 1; k <= 2070; k++) begin
      cycle(1'b0, rnd_data());
      check($sformatf("slip_sched@%0d", k), {13'd0, bitslip},
            {13'd0, (k == 1023 || k == 2062)});
    end

    // ---------------- token on timeout cycle wins ----------------
    cycle(1'b1, 10'h1FF);
    for (int k = 1; k <= 1100; k++) begin
      cycle(1'b0, (k == 1023) ? T2 : rnd_data());
      if (k >= 1020 && k <= 1030)
        check($sformatf("tok_wins@%0d", k), {13'd0, bitslip}, 14'd0);
    end

    // ---------------- randomized against model ----------------
    cycle(1'b1, 10'h000);
    burst = 0;
    for (int k = 0; k < 4000; k++) begin
      logic       r;
      logic [9:0] t;
      r = ($urandom_range(0, 499) == 0);
      if (burst > 0) begin
        burst--;
        case ($urandom_range(0, 3))
          0: t = T0;
          1: t = T1;
          2: t = T2;
          default: t = T3;
        endcase
      end else if ($urandom_range(0, 9) < 2) begin
        burst = $urandom_range(3, 12);
        t = T1;
      end else begin
        t = 10'($urandom);
      end
      cycle(r, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
